// File: rtl/id_word_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : id_word_serializer_if
//  Description : Handshake/status bundle between the ID sampler / LVDA
//                timing logic (master) and the DM word serializer (slave).
//                  DM_IN[WIDTH-1:0] : sampled DM latch bits
//                  LOAD / SHIFT / ABORT : word-time, bit-time and cancel strobes
//                  SDO / SDO_VALID  : serial data bit and its qualifier
//                  BUSY / DONE / OVR: word status back to the controller
//  Revision    : 1.0 - initial release
// ============================================================================
interface id_word_serializer_if #(
  parameter int WIDTH = 6
) ();
  logic [WIDTH-1:0] DM_IN;
  logic             LOAD;
  logic             SHIFT;
  logic             ABORT;
  logic             SDO;
  logic             SDO_VALID;
  logic             BUSY;
  logic             DONE;
  logic             OVR;

  modport master (
    output DM_IN, LOAD, SHIFT, ABORT,
    input  SDO, SDO_VALID, BUSY, DONE, OVR
  );

  modport slave (
    input  DM_IN, LOAD, SHIFT, ABORT,
    output SDO, SDO_VALID, BUSY, DONE, OVR
  );
endinterface
`default_nettype wire

// File: rtl/id_word_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : id_word_serializer
//  Description : Captures the sampled DM latch bits on LOAD and shifts them
//                out MSB-first, one bit per SHIFT strobe, optionally followed
//                by an odd-parity bit. Reports BUSY, a one-cycle DONE pulse
//                and a sticky overrun flag.
//  Ports       : SIM_CLK  - system clock, rising edge
//                SIM_RST  - asynchronous active-low reset
//                bus      - id_word_serializer_if.slave (strobes in, SDO and
//                           status out); all outputs are registered
//  Revision    : 1.0 - initial release
// ============================================================================
module id_word_serializer #(
  parameter int WIDTH  = 6,   // DM bits per word, 2..26
  parameter bit PAR_EN = 1'b1 // append odd-parity bit after the data bits
) (
  input wire logic               SIM_CLK,
  input wire logic               SIM_RST,
  id_word_serializer_if.slave    bus
);

  // Minimum width that holds WIDTH-1 (WIDTH >= 2 keeps this >= 1).
  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic               par_q, par_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sdo_q, sdo_d;
  logic               sdo_valid_q, sdo_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ovr_q, ovr_d;

  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      cnt_q       <= '0;
      sdo_q       <= 1'b0;
      sdo_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      par_q       <= par_d;
      cnt_q       <= cnt_d;
      sdo_q       <= sdo_d;
      sdo_valid_q <= sdo_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    par_d       = par_q;
    cnt_d       = cnt_q;
    sdo_d       = sdo_q;
    sdo_valid_d = sdo_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ovr_d       = ovr_q;

    if (bus.ABORT) begin
      // Cancel wins over LOAD/SHIFT; the overrun history is kept.
      state_d     = S_IDLE;
      shreg_d     = '0;
      cnt_d       = '0;
      sdo_d       = 1'b0;
      sdo_valid_d = 1'b0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.LOAD) begin
            shreg_d     = bus.DM_IN;
            par_d       = ~^bus.DM_IN;
            cnt_d       = '0;
            ovr_d       = 1'b0;
            state_d     = S_DATA;
            sdo_d       = bus.DM_IN[WIDTH-1];
            sdo_valid_d = 1'b1;
            busy_d      = 1'b1;
          end
        end

        S_DATA: begin
          if (bus.LOAD) ovr_d = 1'b1;
          if (bus.SHIFT) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            if (cnt_q == CNT_LAST) begin
              if (PAR_EN) begin
                state_d = S_PARITY;
                sdo_d   = par_q;
              end else begin
                state_d     = S_IDLE;
                cnt_d       = '0;
                done_d      = 1'b1;
                sdo_d       = 1'b0;
                sdo_valid_d = 1'b0;
                busy_d      = 1'b0;
              end
            end else begin
              // The register still holds the current bit in its MSB,
              // so the next bit out is the one just below it.
              sdo_d = shreg_q[WIDTH-2];
              cnt_d = cnt_q + 1'b1;
            end
          end
        end

        S_PARITY: begin
          if (bus.LOAD) ovr_d = 1'b1;
          if (bus.SHIFT) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            done_d      = 1'b1;
            sdo_d       = 1'b0;
            sdo_valid_d = 1'b0;
            busy_d      = 1'b0;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.SDO       = sdo_q;
  assign bus.SDO_VALID = sdo_valid_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.OVR       = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_id_word_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_word_serializer
//  Description : Bench for id_word_serializer. Two instances (parity on and
//                parity off) receive identical strobes; each is compared
//                every cycle against a frame/remaining-bit-count model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_word_serializer;

  logic SIM_CLK = 1'b0;
  logic SIM_RST = 1'b0;
  always #5 SIM_CLK = ~SIM_CLK;

  id_word_serializer_if #(.WIDTH(6)) if_p ();
  id_word_serializer_if #(.WIDTH(6)) if_n ();

  id_word_serializer #(.WIDTH(6), .PAR_EN(1'b1)) u_dut_p (
    .SIM_CLK (SIM_CLK),
    .SIM_RST (SIM_RST),
    .bus     (if_p)
  );

  id_word_serializer #(.WIDTH(6), .PAR_EN(1'b0)) u_dut_n (
    .SIM_CLK (SIM_CLK),
    .SIM_RST (SIM_RST),
    .bus     (if_n)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference: the frame to send (data then optional parity, LSB sent last)
  // and how many of its bits are still to go. Index 0 = parity on, 1 = off.
  logic [6:0] frame [2];
  int         rem   [2];
  bit         mdone [2];
  bit         movr  [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      frame[k] = '0; rem[k] = 0; mdone[k] = 1'b0; movr[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input bit ld, input bit sh, input bit ab,
                            input logic [5:0] dm);
    bit par;
    par      = (k == 0);
    mdone[k] = 1'b0;
    if (ab) begin
      rem[k] = 0;
    end else if (rem[k] == 0) begin
      if (ld) begin
        frame[k] = par ? {dm, ~^dm} : {1'b0, dm};
        rem[k]   = par ? 7 : 6;
        movr[k]  = 1'b0;
      end
    end else begin
      if (ld) movr[k] = 1'b1;
      if (sh) begin
        rem[k]--;
        if (rem[k] == 0) mdone[k] = 1'b1;
      end
    end
  endtask

  task automatic check_dut(input int k, input logic sdo, input logic vld,
                           input logic busy, input logic done, input logic ovr);
    logic exp_sdo;
    exp_sdo = (rem[k] > 0) ? frame[k][rem[k]-1] : 1'b0;
    check($sformatf("u%0d sdo", k),  {31'd0, sdo},  {31'd0, exp_sdo});
    check($sformatf("u%0d vld", k),  {31'd0, vld},  {31'd0, rem[k] > 0});
    check($sformatf("u%0d busy", k), {31'd0, busy}, {31'd0, rem[k] > 0});
    check($sformatf("u%0d done", k), {31'd0, done}, {31'd0, mdone[k]});
    check($sformatf("u%0d ovr", k),  {31'd0, ovr},  {31'd0, movr[k]});
  endtask

  task automatic check_all();
    check_dut(0, if_p.SDO, if_p.SDO_VALID, if_p.BUSY, if_p.DONE, if_p.OVR);
    check_dut(1, if_n.SDO, if_n.SDO_VALID, if_n.BUSY, if_n.DONE, if_n.OVR);
  endtask

  // Drive one cycle of strobes, advance the model at the edge, check at +1.
  task automatic cycle(input bit ld, input bit sh, input bit ab, input logic [5:0] dm);
    if_p.LOAD = ld; if_p.SHIFT = sh; if_p.ABORT = ab; if_p.DM_IN = dm;
    if_n.LOAD = ld; if_n.SHIFT = sh; if_n.ABORT = ab; if_n.DM_IN = dm;
    @(posedge SIM_CLK);
    if (SIM_RST) begin
      model_step(0, ld, sh, ab, dm);
      model_step(1, ld, sh, ab, dm);
    end
    #1;
    check_all();
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 6'($urandom));
  endtask

  task automatic load(input logic [5:0] dm);
    cycle(1'b1, 1'b0, 1'b0, dm);
  endtask

  task automatic shifts_spaced(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) idle();
      cycle(1'b0, 1'b1, 1'b0, 6'($urandom));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    model_reset();
    if_p.LOAD = 0; if_p.SHIFT = 0; if_p.ABORT = 0; if_p.DM_IN = '0;
    if_n.LOAD = 0; if_n.SHIFT = 0; if_n.ABORT = 0; if_n.DM_IN = '0;

    // Reset state, with strobes active while held in reset.
    repeat (2) cycle(1'b1, 1'b1, 1'b0, 6'h3F);
    @(negedge SIM_CLK);
    SIM_RST = 1'b1;
    idle();

    // Basic word with parity, strobes 3 cycles apart.
    load(6'b101100);
    shifts_spaced(7, 2);
    repeat (3) idle();

    // All-zero word (parity 1) and all-one word.
    load(6'b000000);
    shifts_spaced(7, 2);
    repeat (2) idle();
    load(6'b111111);
    shifts_spaced(7, 2);
    repeat (2) idle();

    // Overrun: LOAD after the 2nd SHIFT, then a clean LOAD of the same data.
    load(6'b110010);
    shifts_spaced(2, 1);
    load(6'b010101);
    shifts_spaced(5, 1);
    repeat (2) idle();
    load(6'b010101);
    shifts_spaced(7, 1);
    idle();

    // Overrun coincident with the final SHIFT of the parity-off unit.
    load(6'b100111);
    shifts_spaced(5, 0);
    cycle(1'b1, 1'b1, 1'b0, 6'b000001);
    cycle(1'b0, 1'b1, 1'b0, 6'b000001);
    repeat (2) idle();

    // Abort with LOAD and SHIFT in the same cycle, then a clean word.
    load(6'b011011);
    shifts_spaced(3, 1);
    cycle(1'b1, 1'b1, 1'b1, 6'b111000);
    idle();
    load(6'b100101);
    shifts_spaced(7, 0);
    idle();

    // LOAD on the DONE cycle (parity-on unit after 7 shifts, then off unit after 6).
    load(6'b001110);
    shifts_spaced(7, 0);
    load(6'b110001);
    shifts_spaced(7, 0);
    repeat (2) idle();
    load(6'b101010);
    shifts_spaced(6, 0);
    load(6'b010011);
    shifts_spaced(7, 0);
    idle();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 9) == 0, $urandom_range(0, 9) < 4,
            $urandom_range(0, 39) == 0, 6'($urandom));
    end

    // Asynchronous reset mid-word, between edges.
    repeat (2) idle();
    load(6'b111101);
    shifts_spaced(2, 0);
    #2;
    SIM_RST = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (2) cycle(1'b0, 1'b1, 1'b0, 6'($urandom));
    @(negedge SIM_CLK);
    SIM_RST = 1'b1;
    repeat (4) cycle(1'b0, 1'b1, 1'b0, 6'($urandom));
    load(6'b011110);
    shifts_spaced(7, 1);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
